// File: rtl/overcooked_pkg.sv
// Shared types and helpers for the kitchen game motion logic.
// Direction, key codes, FSM states and clamped step arithmetic.
package overcooked_pkg;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef enum logic [1:0] {
    WAIT_TICK,
    EVAL,
    UPDATE
  } motion_state_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  // Step down by one stride, saturating at the lower bound (11-bit math).
  function automatic logic [9:0] step_dec(
    input logic [9:0] pos,
    input logic [9:0] step,
    input logic [9:0] lo
  );
    logic [10:0] diff;
    diff = {1'b0, pos} - {1'b0, step};
    if ({1'b0, pos} < ({1'b0, lo} + {1'b0, step}))
      return lo;
    else
      return diff[9:0];
  endfunction

  // Step up by one stride, saturating at the upper bound (11-bit math).
  function automatic logic [9:0] step_inc(
    input logic [9:0] pos,
    input logic [9:0] step,
    input logic [9:0] hi
  );
    logic [10:0] sum;
    sum = {1'b0, pos} + {1'b0, step};
    if (sum > {1'b0, hi})
      return hi;
    else
      return sum[9:0];
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the vsync-rate frame strobe into the Clk domain.
// Emits a single-cycle tick on each rising edge.
module frame_tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_clk,
  output logic tick
);

  logic [2:0] sync_q;

  // Two synchroniser flops followed by an edge-history flop.
  always_ff @(posedge clk) begin
    if (!rst_n)
      sync_q <= '0;
    else
      sync_q <= {sync_q[1:0], frame_clk};
  end

  assign tick = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/penguin_motion.sv
// Penguin position/facing register with a per-frame step FSM.
// Steps are blocked by wall flags and clamped to the kitchen bounds.
module penguin_motion
  import overcooked_pkg::*;
#(
  parameter logic [9:0] X_INIT = 10'd100,
  parameter logic [9:0] Y_INIT = 10'd260,
  parameter logic [9:0] STEP   = 10'd2,
  parameter logic [9:0] X_MIN  = 10'd20,
  parameter logic [9:0] X_MAX  = 10'd580,
  parameter logic [9:0] Y_MIN  = 10'd60,
  parameter logic [9:0] Y_MAX  = 10'd320
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       freeze,
  input  logic       touchingUpWallFlag,
  input  logic       touchingDownWallFlag,
  input  logic       touchingLeftWallFlag,
  input  logic       touchingRightWallFlag,
  output logic [9:0] penguinX,
  output logic [9:0] penguinY,
  output dir_t       facing,
  output logic       moving
);

  logic          tick;
  motion_state_t state, state_next;
  logic          latch_en, eval_en, commit_en;

  logic [7:0]    key_q;
  logic          frz_q, up_q, dn_q, lf_q, rt_q;

  dir_t          dir_c;
  logic          valid_c, allow_c, block_c;
  logic [9:0]    cx_c, cy_c;

  dir_t          dir_q;
  logic          face_q, allow_q;
  logic [9:0]    cx_q, cy_q;

  frame_tick_sync u_sync (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset_n)
      state <= WAIT_TICK;
    else
      state <= state_next;
  end

  // Next-state and stage enables; ticks outside WAIT_TICK are dropped.
  always_comb begin
    state_next = state;
    latch_en   = 1'b0;
    eval_en    = 1'b0;
    commit_en  = 1'b0;
    unique case (state)
      WAIT_TICK: begin
        if (tick) begin
          latch_en   = 1'b1;
          state_next = EVAL;
        end
      end
      EVAL: begin
        eval_en    = 1'b1;
        state_next = UPDATE;
      end
      UPDATE: begin
        commit_en  = 1'b1;
        state_next = WAIT_TICK;
      end
      default: state_next = WAIT_TICK;
    endcase
  end

  // Snapshot of inputs taken on the tick cycle.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      key_q <= '0;
      frz_q <= 1'b0;
      up_q  <= 1'b0;
      dn_q  <= 1'b0;
      lf_q  <= 1'b0;
      rt_q  <= 1'b0;
    end else if (latch_en) begin
      key_q <= keycode;
      frz_q <= freeze;
      up_q  <= touchingUpWallFlag;
      dn_q  <= touchingDownWallFlag;
      lf_q  <= touchingLeftWallFlag;
      rt_q  <= touchingRightWallFlag;
    end
  end

  // Decode key, check its wall flag and build the clamped candidate.
  always_comb begin
    dir_c   = DIR_DOWN;
    valid_c = 1'b1;
    block_c = 1'b0;
    cx_c    = penguinX;
    cy_c    = penguinY;
    unique case (key_q)
      KEY_W: dir_c = DIR_UP;
      KEY_S: dir_c = DIR_DOWN;
      KEY_A: dir_c = DIR_LEFT;
      KEY_D: dir_c = DIR_RIGHT;
      default: valid_c = 1'b0;
    endcase
    unique case (dir_c)
      DIR_UP: begin
        block_c = up_q;
        cy_c    = step_dec(penguinY, STEP, Y_MIN);
      end
      DIR_DOWN: begin
        block_c = dn_q;
        cy_c    = step_inc(penguinY, STEP, Y_MAX);
      end
      DIR_LEFT: begin
        block_c = lf_q;
        cx_c    = step_dec(penguinX, STEP, X_MIN);
      end
      DIR_RIGHT: begin
        block_c = rt_q;
        cx_c    = step_inc(penguinX, STEP, X_MAX);
      end
      default: block_c = 1'b1;
    endcase
    allow_c = valid_c & ~frz_q & ~block_c;
  end

  // Register the evaluation result for the commit cycle.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      dir_q   <= DIR_DOWN;
      face_q  <= 1'b0;
      allow_q <= 1'b0;
      cx_q    <= X_INIT;
      cy_q    <= Y_INIT;
    end else if (eval_en) begin
      dir_q   <= dir_c;
      face_q  <= valid_c & ~frz_q;
      allow_q <= allow_c;
      cx_q    <= cx_c;
      cy_q    <= cy_c;
    end
  end

  // Commit position/facing and pulse moving on a real change.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      penguinX <= X_INIT;
      penguinY <= Y_INIT;
      facing   <= DIR_DOWN;
      moving   <= 1'b0;
    end else begin
      moving <= 1'b0;
      if (commit_en) begin
        if (face_q)
          facing <= dir_q;
        if (allow_q && ((cx_q != penguinX) || (cy_q != penguinY))) begin
          penguinX <= cx_q;
          penguinY <= cy_q;
          moving   <= 1'b1;
        end
      end
    end
  end

endmodule
